// File: rtl/rr_burst_scheduler_pkg.sv
// Shared constants for the 4x4 switch round-robin burst scheduler.
package rr_burst_scheduler_pkg;

  localparam int N_PORTS     = 4;
  localparam int DEF_DATA_W  = 10;
  localparam int DEF_DEST_HI = DEF_DATA_W - 1;
  localparam int DEF_DEST_LO = DEF_DATA_W - 2;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  function automatic logic [N_PORTS-1:0] onehot4(input logic [1:0] idx);
    logic [N_PORTS-1:0] oh;
    oh      = 4'b0000;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_burst_scheduler_pick4.sv
// Rotating-priority encoder: first requester after ptr wins, ptr itself is checked last.
module rr_pick4
  import rr_burst_scheduler_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       any
);

  // Scan ptr+1, ptr+2, ptr+3, ptr (mod 4) and latch the first hit
  always_comb begin
    logic [1:0] idx_s;
    logic       take_s;
    gnt     = 4'b0000;
    gnt_idx = 2'd0;
    any     = 1'b0;
    idx_s   = 2'd0;
    take_s  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx_s   = ptr + 2'(k);
      take_s  = req[idx_s] & ~any;
      gnt_idx = take_s ? idx_s : gnt_idx;
      gnt     = gnt | (take_s ? onehot4(idx_s) : 4'b0000);
      any     = any | req[idx_s];
    end
  end

endmodule

// File: rtl/rr_burst_scheduler.sv
// Round-robin burst scheduler: pops the 4 FWFT input FIFOs fairly (up to QUANTUM words
// per grant) and routes each word to the output FIFO named by its dest field.
module rr_burst_scheduler
  import rr_burst_scheduler_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int QUANTUM = 4,
  parameter int CNT_W   = 3
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [3:0]        empty_in,
  input  logic [DATA_W-1:0] head_0,
  input  logic [DATA_W-1:0] head_1,
  input  logic [DATA_W-1:0] head_2,
  input  logic [DATA_W-1:0] head_3,
  input  logic [3:0]        almost_full_out,
  output logic [3:0]        pop_in,
  output logic [3:0]        push_out,
  output logic [DATA_W-1:0] data_out,
  output logic              busy
);

  localparam int               DHI      = DATA_W - 1;
  localparam int               DLO      = DATA_W - 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUANTUM - 1);

  logic [DATA_W-1:0] head_s [N_PORTS];
  logic [3:0]        elig_s;
  logic [3:0]        pick_gnt_s;
  logic [1:0]        pick_idx_s;
  logic              pick_any_s;

  logic [0:0]        state_r;
  logic [0:0]        state_nxt_s;
  logic [1:0]        ptr_r;
  logic [1:0]        ptr_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic [1:0]        sel_s;
  logic              pop_any_s;

  assign head_s[0] = head_0;
  assign head_s[1] = head_1;
  assign head_s[2] = head_2;
  assign head_s[3] = head_3;

  // A port may pop only if its head's destination can take one more word
  always_comb begin
    elig_s = 4'b0000;
    for (int i = 0; i < N_PORTS; i++) begin
      elig_s[i] = enable & ~empty_in[i] & ~almost_full_out[head_s[i][DHI:DLO]];
    end
  end

  rr_pick4 u_pick (
    .req     (elig_s),
    .ptr     (ptr_r),
    .gnt     (pick_gnt_s),
    .gnt_idx (pick_idx_s),
    .any     (pick_any_s)
  );

  // Grant FSM: continue the current burst, rotate on exhaustion/ineligibility, or fall idle
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    cnt_nxt_s   = cnt_r;
    sel_s       = ptr_r;
    pop_any_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_any_s) begin
          sel_s       = pick_idx_s;
          pop_any_s   = 1'b1;
          ptr_nxt_s   = pick_idx_s;
          cnt_nxt_s   = {CNT_W{1'b0}};
          state_nxt_s = BURST;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BURST: begin
        if (elig_s[ptr_r] && (cnt_r < CNT_LAST)) begin
          sel_s     = ptr_r;
          pop_any_s = 1'b1;
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end else if (pick_any_s) begin
          // the picker visits ptr last, so ptr is re-granted only when it is alone
          sel_s     = pick_idx_s;
          pop_any_s = 1'b1;
          ptr_nxt_s = pick_idx_s;
          cnt_nxt_s = {CNT_W{1'b0}};
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  assign pop_in = (pop_any_s && !reset) ? onehot4(sel_s) : 4'b0000;

  // FSM state, rotation pointer and burst counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      ptr_r   <= 2'd3;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Output stage: the popped head is pushed one cycle later; data_out holds between pushes
  always_ff @(posedge clk) begin
    if (reset) begin
      push_out <= 4'b0000;
      data_out <= {DATA_W{1'b0}};
    end else if (pop_any_s) begin
      push_out <= onehot4(head_s[sel_s][DHI:DLO]);
      data_out <= head_s[sel_s];
    end else begin
      push_out <= 4'b0000;
    end
  end

  assign busy = (state_r == BURST);

endmodule

// File: tb/tb_rr_burst_scheduler.sv
// Directed bench for rr_burst_scheduler with queue-based FWFT input FIFO models.
module tb_rr_burst_scheduler;

  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [3:0]    empty_in;
  logic [DW-1:0] head_0, head_1, head_2, head_3;
  logic [3:0]    almost_full_out;
  logic [3:0]    pop_in;
  logic [3:0]    push_out;
  logic [DW-1:0] data_out;
  logic          busy;

  logic [DW-1:0] fq [4][$];
  int            n_total = 0;
  int            n_bad   = 0;

  rr_burst_scheduler #(.DATA_W(DW), .QUANTUM(4), .CNT_W(3)) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .empty_in        (empty_in),
    .head_0          (head_0),
    .head_1          (head_1),
    .head_2          (head_2),
    .head_3          (head_3),
    .almost_full_out (almost_full_out),
    .pop_in          (pop_in),
    .push_out        (push_out),
    .data_out        (data_out),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive FIFO flags/heads from the queue models
  task automatic refresh();
    for (int i = 0; i < 4; i++) empty_in[i] = (fq[i].size() == 0);
    head_0 = (fq[0].size() != 0) ? fq[0][0] : 10'h000;
    head_1 = (fq[1].size() != 0) ? fq[1][0] : 10'h000;
    head_2 = (fq[2].size() != 0) ? fq[2][0] : 10'h000;
    head_3 = (fq[3].size() != 0) ? fq[3][0] : 10'h000;
    #1;
  endtask

  // One clock: the FIFOs consume whatever pop_in requested in the cycle just ending
  task automatic cyc();
    logic [3:0] p;
    p = pop_in;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (p[i] && fq[i].size() != 0) void'(fq[i].pop_front());
    end
    refresh();
  endtask

  initial begin
    int          ports [8];
    int          cnts  [8];
    int          widx  [4];
    logic [DW-1:0] exp_q[$];

    reset = 1'b1; enable = 1'b1; almost_full_out = 4'b0000;
    refresh();
    cyc(); cyc();
    check_val("rst_push", push_out, 4'b0000);
    check_val("rst_data", data_out, 10'h000);
    check_val("rst_busy", busy, 1'b0);

    // single port, three destinations
    fq[1].push_back(10'h100); fq[1].push_back(10'h200); fq[1].push_back(10'h300);
    refresh();
    check_val("rst_pop", pop_in, 4'b0000);
    reset = 1'b0; refresh();
    check_val("t3_pop0", pop_in, 4'b0010);
    cyc();
    check_val("t3_push0", push_out, 4'b0010); check_val("t3_data0", data_out, 10'h100);
    check_val("t3_pop1", pop_in, 4'b0010);    check_val("t3_busy", busy, 1'b1);
    cyc();
    check_val("t3_push1", push_out, 4'b0100); check_val("t3_data1", data_out, 10'h200);
    check_val("t3_pop2", pop_in, 4'b0010);
    cyc();
    check_val("t3_push2", push_out, 4'b1000); check_val("t3_data2", data_out, 10'h300);
    check_val("t3_pop3", pop_in, 4'b0000);
    cyc();
    check_val("t3_push3", push_out, 4'b0000); check_val("t3_hold", data_out, 10'h300);
    check_val("t3_idle", busy, 1'b0);

    // reset in the middle of a burst
    fq[1].push_back(10'h011); fq[1].push_back(10'h022); fq[1].push_back(10'h033);
    refresh();
    check_val("t1_pop0", pop_in, 4'b0010);
    cyc();
    check_val("t1_push0", push_out, 4'b0001); check_val("t1_data0", data_out, 10'h011);
    reset = 1'b1; refresh();
    check_val("t1_rpop", pop_in, 4'b0000);
    cyc();
    check_val("t1_rpush", push_out, 4'b0000); check_val("t1_rdata", data_out, 10'h000);
    check_val("t1_rbusy", busy, 1'b0);
    fq[0].push_back(10'h0A5);
    reset = 1'b0; refresh();
    check_val("t1_p0first", pop_in, 4'b0001);
    cyc();
    check_val("t1_d0a5", data_out, 10'h0A5); check_val("t1_rot", pop_in, 4'b0010);
    cyc();
    check_val("t1_d022", data_out, 10'h022); check_val("t1_pop", pop_in, 4'b0010);
    cyc();
    check_val("t1_d033", data_out, 10'h033); check_val("t1_popz", pop_in, 4'b0000);
    cyc();
    check_val("t1_end", push_out, 4'b0000);

    // four full ports, quantum rotation with no bubbles
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 6; k++) fq[i].push_back(10'(i * 16 + k));
    end
    refresh();
    cyc();
    reset = 1'b0; refresh();
    ports = '{0, 1, 2, 3, 0, 1, 2, 3};
    cnts  = '{4, 4, 4, 4, 2, 2, 2, 2};
    widx  = '{0, 0, 0, 0};
    for (int s = 0; s < 8; s++) begin
      for (int c = 0; c < cnts[s]; c++) begin
        exp_q.push_back(10'(ports[s] * 16 + widx[ports[s]]));
        widx[ports[s]]++;
      end
    end
    for (int n = 0; n < 24; n++) begin
      cyc();
      check_val($sformatf("t2_push%0d", n), push_out, 4'b0001);
      check_val($sformatf("t2_data%0d", n), data_out, exp_q[n]);
    end
    cyc();
    check_val("t2_push_end", push_out, 4'b0000); check_val("t2_busy_end", busy, 1'b0);

    // backpressure skip, then recovery
    almost_full_out = 4'b0100;
    fq[0].push_back(10'h2AA); fq[1].push_back(10'h3B1); fq[1].push_back(10'h3B2);
    refresh();
    check_val("t4_skip", pop_in, 4'b0010);
    cyc();
    check_val("t4_push0", push_out, 4'b1000); check_val("t4_data0", data_out, 10'h3B1);
    almost_full_out = 4'b0000; refresh();
    check_val("t4_cont", pop_in, 4'b0010);
    cyc();
    check_val("t4_data1", data_out, 10'h3B2); check_val("t4_p0", pop_in, 4'b0001);
    cyc();
    check_val("t4_push2", push_out, 4'b0100); check_val("t4_data2", data_out, 10'h2AA);
    check_val("t4_popz", pop_in, 4'b0000);
    cyc();

    // sole port, re-granted across quantum boundaries
    for (int n = 0; n < 10; n++) fq[2].push_back(10'h100 + 10'(n));
    refresh();
    check_val("t5_pop_first", pop_in, 4'b0100);
    for (int n = 0; n < 10; n++) begin
      cyc();
      check_val($sformatf("t5_push%0d", n), push_out, 4'b0010);
      check_val($sformatf("t5_data%0d", n), data_out, 10'h100 + 10'(n));
      check_val($sformatf("t5_busy%0d", n), busy, 1'b1);
      if (n < 9) check_val($sformatf("t5_pop%0d", n), pop_in, 4'b0100);
      else       check_val("t5_pop_last", pop_in, 4'b0000);
    end
    cyc();
    check_val("t5_end", push_out, 4'b0000); check_val("t5_idle", busy, 1'b0);

    // enable dropped for three cycles mid-burst
    for (int n = 0; n < 6; n++) fq[3].push_back(10'h300 + 10'(n));
    fq[0].push_back(10'h0C0); fq[0].push_back(10'h0C1);
    refresh();
    check_val("t6_pop_a", pop_in, 4'b1000);
    cyc();
    check_val("t6_data_b", data_out, 10'h300); check_val("t6_pop_b", pop_in, 4'b1000);
    cyc();
    enable = 1'b0; refresh();
    check_val("t6_trail_push", push_out, 4'b1000); check_val("t6_trail_data", data_out, 10'h301);
    check_val("t6_dis_pop_c", pop_in, 4'b0000);
    cyc();
    check_val("t6_dis_push_d", push_out, 4'b0000); check_val("t6_dis_pop_d", pop_in, 4'b0000);
    check_val("t6_dis_busy_d", busy, 1'b0);
    cyc();
    check_val("t6_dis_push_e", push_out, 4'b0000); check_val("t6_dis_pop_e", pop_in, 4'b0000);
    enable = 1'b1; refresh();
    check_val("t6_resume", pop_in, 4'b0001);
    cyc();
    check_val("t6_d0c0", data_out, 10'h0C0); check_val("t6_pop_c1", pop_in, 4'b0001);
    cyc();
    check_val("t6_d0c1", data_out, 10'h0C1); check_val("t6_back3", pop_in, 4'b1000);
    for (int k = 0; k < 4; k++) begin
      cyc();
      check_val($sformatf("t6_push3_%0d", k), push_out, 4'b1000);
      check_val($sformatf("t6_data3_%0d", k), data_out, 10'h302 + 10'(k));
    end
    cyc();
    check_val("t6_end", push_out, 4'b0000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
